// File: rtl/instruction_ram_if.sv
// Fetch and load port bundle for instruction_ram.
// The master side is the PC/fetch logic plus host loader; the slave side is the RAM.
interface instruction_ram_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 8
);
   logic                  fetch_req;
   logic [15:0]           fetch_addr;
   logic                  fetch_ready;
   logic                  fetch_valid;
   logic [DATA_WIDTH-1:0] fetch_instr;
   logic                  load_start;
   logic                  load_valid;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_ready;
   logic                  load_done;
   logic                  load_ovf;
   logic [ADDR_WIDTH:0]   prog_len;

   modport master (
      output fetch_req, fetch_addr, load_start, load_valid, load_data, load_done,
      input  fetch_ready, fetch_valid, fetch_instr, load_ready, load_ovf, prog_len
   );

   modport slave (
      input  fetch_req, fetch_addr, load_start, load_valid, load_data, load_done,
      output fetch_ready, fetch_valid, fetch_instr, load_ready, load_ovf, prog_len
   );
endinterface

// File: rtl/instruction_ram.sv
// Loadable program store: streamed in over the load port, read by fetch with one cycle
// of latency. Words at or beyond the loaded program length read back as NOP_WORD.
module instruction_ram #(
   parameter int unsigned           DATA_WIDTH = 16,
   parameter int unsigned           ADDR_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
   input logic              clk,
   input logic              rst_n,
   instruction_ram_if.slave bus
);
   localparam int unsigned         DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FULL  = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH + 1)'(1);

   typedef enum logic [0:0] {StRun, StLoad} state_e;

   state_e                state_q, state_d;
   // prog_len always equals the write pointer, so one register serves both
   logic [ADDR_WIDTH:0]   ptr_q, ptr_d;
   logic                  ovf_q, ovf_d;
   logic                  fetch_valid_q, fetch_valid_d;
   logic [DATA_WIDTH-1:0] fetch_instr_q, fetch_instr_d;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic load_ready;
   logic wr_en;
   logic ovf_set;
   logic fetch_fire;
   logic fetch_hit;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= StRun;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:   if (bus.load_start) state_d = StLoad;
         StLoad: begin
            if (bus.load_start)     state_d = StLoad;
            else if (bus.load_done) state_d = StRun;
         end
         default: state_d = StRun;
      endcase
   end

   always_comb begin
      bus.fetch_ready = (state_q == StRun);
      load_ready      = (state_q == StLoad) && (ptr_q != FULL);
      bus.load_ready  = load_ready;
   end

   // load_start wins over writes, overflow and fetches in the same cycle
   always_comb begin
      wr_en      = (state_q == StLoad) && bus.load_valid && load_ready && !bus.load_start;
      ovf_set    = (state_q == StLoad) && bus.load_valid && !load_ready && !bus.load_start;
      fetch_fire = (state_q == StRun) && bus.fetch_req && !bus.load_start;
      fetch_hit  = {1'b0, bus.fetch_addr} < 17'(ptr_q);

      ptr_d = ptr_q;
      ovf_d = ovf_q;
      if (bus.load_start) begin
         ptr_d = '0;
         ovf_d = 1'b0;
      end else if (wr_en) begin
         ptr_d = ptr_q + ONE;
      end else if (ovf_set) begin
         ovf_d = 1'b1;
      end

      fetch_valid_d = fetch_fire;
      fetch_instr_d = fetch_instr_q;
      if (fetch_fire) begin
         fetch_instr_d = fetch_hit ? mem[bus.fetch_addr[ADDR_WIDTH-1:0]] : NOP_WORD;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q         <= '0;
         ovf_q         <= 1'b0;
         fetch_valid_q <= 1'b0;
         fetch_instr_q <= NOP_WORD;
      end else begin
         ptr_q         <= ptr_d;
         ovf_q         <= ovf_d;
         fetch_valid_q <= fetch_valid_d;
         fetch_instr_q <= fetch_instr_d;
      end
   end

   // Storage is never cleared; prog_len alone decides what is readable
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) mem[ptr_q[ADDR_WIDTH-1:0]] <= bus.load_data;
   end

   assign bus.fetch_valid = fetch_valid_q;
   assign bus.fetch_instr = fetch_instr_q;
   assign bus.load_ovf    = ovf_q;
   assign bus.prog_len    = ptr_q;
endmodule
